mem_stage_arbiter: RTL and testbench
====================================

# mem_stage_arbiter

Sequences the data-memory access of the CPU's memory stage and shares the single-port data SRAM with one external requester (DMA/debug port). Sits between the EX/MEM pipeline register outputs and the data memory. Each access runs through a multi-cycle state machine with programmable wait states, and the block holds the pipeline with a stall until a CPU access completes.

## Interface
- WAIT_CYCLES, 1, extra memory wait states per access (0..7)
- DW, 16, data width
- AW, 16, address width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- cpu_req  in  1  memory-stage access request (MemWriteM | MemToRegM)
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  AW  address (ALU result of memory stage)
- cpu_wdata  in  DW  store data
- cpu_rdata  out  DW  load data, valid while cpu_stall low after a CPU load
- cpu_stall  out  1  freeze IF..MEM pipeline registers
- ext_req  in  1  external request, level, held until ext_done
- ext_we, ext_addr[AW], ext_wdata[DW]  in  external command, stable while ext_req high
- ext_gnt  out  1  external transaction owns memory
- ext_done  out  1  one-cycle completion pulse
- ext_rdata  out  DW  external load data, held until next external transaction
- mem_en, mem_we  out  1  SRAM enable / write enable
- mem_addr  out  AW;  mem_wdata  out  DW;  mem_rdata  in  DW

## Operation
- States: IDLE, BUSY, DONE. Registers: owner (CPU/EXT), latched we/addr/wdata, wait counter, last_owner.
- IDLE: if any request, pick winner, latch its command, counter <= WAIT_CYCLES, go to BUSY. No request: stay.
- BUSY: mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values. Counter decrements each cycle; at counter==0, sample mem_rdata into winner's rdata register (loads only), go to DONE.
- DONE: owner CPU -> cpu_stall low this cycle; owner EXT -> ext_done=1. Next state IDLE unconditionally.
- cpu_stall = cpu_req & !(state==DONE & owner==CPU); forced 0 while reset low.
- ext_gnt = owner==EXT in BUSY or DONE.
- Arbitration default: fixed priority, CPU wins every tie; external requester can starve under continuous CPU traffic (accepted).
- Request dropped during BUSY (flush): transaction still completes; a store is committed; rdata is updated but ignored.
- Store data is never re-sampled from inputs after IDLE latch.

## Timing
- Access latency from request visible in IDLE to completion cycle: WAIT_CYCLES+2 cycles; CPU stall length WAIT_CYCLES+2 cycles per load/store.
- mem_en high for exactly WAIT_CYCLES+1 consecutive cycles per access; mem_rdata must be valid in the last of them.
- Back-to-back: minimum one IDLE cycle between accesses (throughput 1 per WAIT_CYCLES+3 cycles).
- Reset (async): state IDLE, owner CPU, last_owner EXT, counter 0; all outputs 0 (cpu_rdata, ext_rdata = 0). Reset mid-BUSY aborts immediately: mem_en drops asynchronously, no ext_done, write may be partial.

## Configuration
- ARB_FAIR_EN defined: round-robin. On a tie in IDLE, grant the requester not equal to last_owner; last_owner updated on every grant. Reset last_owner = EXT so first tie goes to CPU.
- ARB_FAIR_EN undefined: fixed CPU priority as above; last_owner register not built.

## Test plan
- WAIT_CYCLES=1, CPU store addr 0x0040 data 0xBEEF -> mem_en/mem_we high 2 cycles with addr 0x0040, cpu_stall high 3 cycles, then low one cycle; SRAM holds 0xBEEF.
- CPU load 0x0040 -> cpu_rdata=0xBEEF in DONE cycle with cpu_stall low.
- ext load 0x0010 (SRAM 0x1234), no CPU traffic -> ext_gnt high 3 cycles, ext_done pulse with ext_rdata=0x1234.
- cpu_req and ext_req rise same cycle, fixed mode -> CPU served first, ext_done 4 cycles later; with ARB_FAIR_EN and two consecutive ties -> CPU, EXT, CPU alternating.
- Reset asserted in 2nd BUSY cycle of ext store -> mem_en 0 immediately, no ext_done, ext_gnt 0, cpu_stall 0; after release, fresh request completes normally.
- WAIT_CYCLES=0, cpu_req withdrawn during BUSY -> store still written, FSM returns to IDLE, no stall afterwards.

Source files
------------

// File: rtl/mem_stage_arbiter.sv
// Memory-stage SRAM sequencer shared between the CPU pipeline and one external port.
// Define ARB_FAIR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_stage_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_done,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES);

    state_t        state;
    state_t        stateNext;
    logic          ownerExt;
    logic          grantExt;
    logic          anyReq;
    logic          weQ;
    logic [AW-1:0] addrQ;
    logic [DW-1:0] wdataQ;
    logic [DW-1:0] cpuRdataQ;
    logic [DW-1:0] extRdataQ;
    logic [2:0]    waitCnt;

    assign anyReq = cpu_req | ext_req;

`ifdef ARB_FAIR_EN
    logic lastOwnerExt;

    // On a tie the requester that did not win last time gets the memory.
    assign grantExt = ext_req & (!cpu_req | !lastOwnerExt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastOwnerExt <= 1'b1;
        end else if (state == IDLE && anyReq) begin
            lastOwnerExt <= grantExt;
        end
    end
`else
    assign grantExt = ext_req & !cpu_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        ext_gnt   = 1'b0;
        ext_done  = 1'b0;
        cpu_stall = reset & cpu_req;
        unique case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                mem_en  = 1'b1;
                mem_we  = weQ;
                ext_gnt = ownerExt;
                if (waitCnt == 3'd0) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
                ext_gnt   = ownerExt;
                ext_done  = ownerExt;
                if (!ownerExt) begin
                    cpu_stall = 1'b0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Command is captured once in IDLE; inputs are not looked at again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ownerExt  <= 1'b0;
            weQ       <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            waitCnt   <= 3'd0;
            cpuRdataQ <= '0;
            extRdataQ <= '0;
        end else begin
            if (state == IDLE && anyReq) begin
                ownerExt <= grantExt;
                weQ      <= grantExt ? ext_we : cpu_we;
                addrQ    <= grantExt ? ext_addr : cpu_addr;
                wdataQ   <= grantExt ? ext_wdata : cpu_wdata;
                waitCnt  <= WaitInit;
            end else if (state == BUSY) begin
                if (waitCnt != 3'd0) begin
                    waitCnt <= waitCnt - 3'd1;
                end else if (!weQ) begin
                    if (ownerExt) begin
                        extRdataQ <= mem_rdata;
                    end else begin
                        cpuRdataQ <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_addr  = addrQ;
    assign mem_wdata = wdataQ;
    assign cpu_rdata = cpuRdataQ;
    assign ext_rdata = extRdataQ;

endmodule

// File: tb/tb_mem_stage_arbiter.sv
// Directed bench for mem_stage_arbiter: WAIT_CYCLES=1 main instance,
// plus a WAIT_CYCLES=0 instance sharing the same request inputs.
module tb_mem_stage_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuReq;
    logic        cpuWe;
    logic [15:0] cpuAddr;
    logic [15:0] cpuWdata;
    logic        extReq;
    logic        extWe;
    logic [15:0] extAddr;
    logic [15:0] extWdata;

    logic [15:0] cpuRdata1, extRdata1, memAddr1, memWdata1, memRdata1;
    logic        cpuStall1, extGnt1, extDone1, memEn1, memWe1;
    logic [15:0] cpuRdata0, extRdata0, memAddr0, memWdata0, memRdata0;
    logic        cpuStall0, extGnt0, extDone0, memEn0, memWe0;

    logic [15:0] sram1 [0:255];
    logic [15:0] sram0 [0:255];

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    mem_stage_arbiter #(.WAIT_CYCLES(1), .DW(16), .AW(16)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpuReq), .cpu_we(cpuWe),
        .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_rdata(cpuRdata1), .cpu_stall(cpuStall1),
        .ext_req(extReq), .ext_we(extWe),
        .ext_addr(extAddr), .ext_wdata(extWdata),
        .ext_gnt(extGnt1), .ext_done(extDone1), .ext_rdata(extRdata1),
        .mem_en(memEn1), .mem_we(memWe1), .mem_addr(memAddr1),
        .mem_wdata(memWdata1), .mem_rdata(memRdata1)
    );

    mem_stage_arbiter #(.WAIT_CYCLES(0), .DW(16), .AW(16)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpuReq), .cpu_we(cpuWe),
        .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_rdata(cpuRdata0), .cpu_stall(cpuStall0),
        .ext_req(extReq), .ext_we(extWe),
        .ext_addr(extAddr), .ext_wdata(extWdata),
        .ext_gnt(extGnt0), .ext_done(extDone0), .ext_rdata(extRdata0),
        .mem_en(memEn0), .mem_we(memWe0), .mem_addr(memAddr0),
        .mem_wdata(memWdata0), .mem_rdata(memRdata0)
    );

    // SRAM models: synchronous write, combinational read
    always @(posedge clk) begin
        if (memEn1 && memWe1) sram1[memAddr1[7:0]] <= memWdata1;
        if (memEn0 && memWe0) sram0[memAddr0[7:0]] <= memWdata0;
    end
    assign memRdata1 = sram1[memAddr1[7:0]];
    assign memRdata0 = sram0[memAddr0[7:0]];

    task automatic checkEq(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpuAccess(input string p, input logic we,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] rdExp);
        cpuReq   = 1'b1;
        cpuWe    = we;
        cpuAddr  = addr;
        cpuWdata = wdata;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkEq({p, ".stall"}, 16'(cpuStall1), (i < 3) ? 16'd1 : 16'd0);
            checkEq({p, ".memEn"}, 16'(memEn1),
                    (i == 1 || i == 2) ? 16'd1 : 16'd0);
            checkEq({p, ".gnt"}, 16'(extGnt1), 16'd0);
            if (i == 1) begin
                checkEq({p, ".memWe"}, 16'(memWe1), 16'(we));
                checkEq({p, ".memAddr"}, memAddr1, addr);
            end
            if (i == 3 && !we) checkEq({p, ".rdata"}, cpuRdata1, rdExp);
            tick;
        end
        cpuReq = 1'b0;
    endtask

    task automatic extAccess(input string p, input logic we,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] rdExp);
        extReq   = 1'b1;
        extWe    = we;
        extAddr  = addr;
        extWdata = wdata;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkEq({p, ".gnt"}, 16'(extGnt1), (i >= 1) ? 16'd1 : 16'd0);
            checkEq({p, ".done"}, 16'(extDone1), (i == 3) ? 16'd1 : 16'd0);
            checkEq({p, ".stall"}, 16'(cpuStall1), 16'd0);
            if (i == 3 && !we) checkEq({p, ".rdata"}, extRdata1, rdExp);
            tick;
        end
        extReq = 1'b0;
        @(negedge clk);
        checkEq({p, ".gntAfter"}, 16'(extGnt1), 16'd0);
        checkEq({p, ".doneAfter"}, 16'(extDone1), 16'd0);
        tick;
    endtask

    initial begin
        reset    = 1'b0;
        cpuReq   = 1'b1;
        cpuWe    = 1'b0;
        cpuAddr  = '0;
        cpuWdata = '0;
        extReq   = 1'b0;
        extWe    = 1'b0;
        extAddr  = '0;
        extWdata = '0;
        #2;
        checkEq("rst.stall", 16'(cpuStall1), 16'd0);
        checkEq("rst.memEn", 16'(memEn1), 16'd0);
        checkEq("rst.gnt", 16'(extGnt1), 16'd0);
        checkEq("rst.done", 16'(extDone1), 16'd0);
        checkEq("rst.cpuRdata", cpuRdata1, 16'h0000);
        checkEq("rst.extRdata", extRdata1, 16'h0000);
        cpuReq = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick;

        cpuAccess("st40", 1'b1, 16'h0040, 16'hBEEF, 16'h0000);
        checkEq("st40.sram", sram1[8'h40], 16'hBEEF);
        cpuAccess("ld40", 1'b0, 16'h0040, 16'h0000, 16'hBEEF);
        cpuAccess("st10", 1'b1, 16'h0010, 16'h1234, 16'h0000);
        extAccess("xld10", 1'b0, 16'h0010, 16'h0000, 16'h1234);

        // Simultaneous requests: CPU load first, then external store
        cpuReq   = 1'b1;
        cpuWe    = 1'b0;
        cpuAddr  = 16'h0010;
        extReq   = 1'b1;
        extWe    = 1'b1;
        extAddr  = 16'h0020;
        extWdata = 16'h5A5A;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkEq("tie.stall", 16'(cpuStall1), (i < 3) ? 16'd1 : 16'd0);
            checkEq("tie.gnt", 16'(extGnt1), (i >= 5) ? 16'd1 : 16'd0);
            checkEq("tie.done", 16'(extDone1), (i == 7) ? 16'd1 : 16'd0);
            if (i == 3) checkEq("tie.cpuRdata", cpuRdata1, 16'h1234);
            tick;
            if (i == 3) cpuReq = 1'b0;
        end
        extReq = 1'b0;
        @(negedge clk);
        checkEq("tie.sram", sram1[8'h20], 16'h5A5A);
        tick;

        // Reset during the second BUSY cycle of an external store
        extReq   = 1'b1;
        extWe    = 1'b1;
        extAddr  = 16'h0030;
        extWdata = 16'h7777;
        tick;
        tick;
        #2;
        checkEq("rstBusy.memEnPre", 16'(memEn1), 16'd1);
        reset  = 1'b0;
        cpuReq = 1'b1;
        #1;
        checkEq("rstBusy.memEn", 16'(memEn1), 16'd0);
        checkEq("rstBusy.gnt", 16'(extGnt1), 16'd0);
        checkEq("rstBusy.done", 16'(extDone1), 16'd0);
        checkEq("rstBusy.stall", 16'(cpuStall1), 16'd0);
        tick;
        checkEq("rstBusy.doneLater", 16'(extDone1), 16'd0);
        checkEq("rstBusy.extRdata", extRdata1, 16'h0000);
        @(negedge clk);
        reset  = 1'b1;
        cpuReq = 1'b0;
        extReq = 1'b0;
        tick;
        extAccess("xldPost", 1'b0, 16'h0010, 16'h0000, 16'h1234);

        for (int i = 0; i < 4; i++) tick;

        // Zero wait states: store request withdrawn once BUSY is entered
        cpuReq   = 1'b1;
        cpuWe    = 1'b1;
        cpuAddr  = 16'h0050;
        cpuWdata = 16'hCAFE;
        @(negedge clk);
        checkEq("w0.stallIdle", 16'(cpuStall0), 16'd1);
        checkEq("w0.memEnIdle", 16'(memEn0), 16'd0);
        tick;
        cpuReq   = 1'b0;
        cpuWdata = 16'hFFFF;
        @(negedge clk);
        checkEq("w0.memEn", 16'(memEn0), 16'd1);
        checkEq("w0.memWe", 16'(memWe0), 16'd1);
        checkEq("w0.memWdata", memWdata0, 16'hCAFE);
        checkEq("w0.stallBusy", 16'(cpuStall0), 16'd0);
        tick;
        @(negedge clk);
        checkEq("w0.memEnDone", 16'(memEn0), 16'd0);
        checkEq("w0.stallDone", 16'(cpuStall0), 16'd0);
        tick;
        @(negedge clk);
        checkEq("w0.memEnIdle2", 16'(memEn0), 16'd0);
        checkEq("w0.sram", sram0[8'h50], 16'hCAFE);
        checkEq("w0.stallIdle2", 16'(cpuStall0), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
